// File: rtl/pri_analyzer_if.sv
// Bundle between the pulse detector and the PRI analyser: detector
// outputs (enable, PC, TOA) in one direction and PRI statistics in the other.
interface pri_analyzer_if #(
  parameter int TIME_W = 32
);
  logic              enable;
  logic [TIME_W-1:0] PC;
  logic [TIME_W-1:0] TOA;
  logic [TIME_W-1:0] PRI;
  logic [TIME_W-1:0] PRI_AVG;
  logic [TIME_W-1:0] PRI_MIN;
  logic [TIME_W-1:0] PRI_MAX;
  logic              pri_valid;
  logic              stable;
  logic              window_done;
  logic [15:0]       resync_cnt;

  modport master (
    output enable, PC, TOA,
    input  PRI, PRI_AVG, PRI_MIN, PRI_MAX, pri_valid, stable, window_done, resync_cnt
  );

  modport slave (
    input  enable, PC, TOA,
    output PRI, PRI_AVG, PRI_MIN, PRI_MAX, pri_valid, stable, window_done, resync_cnt
  );
endinterface

// File: rtl/pri_analyzer.sv
// Pulse repetition interval analyser: measures intervals between detector
// pulses, publishes windowed average/min/max and a jitter-stability flag.
module pri_analyzer #(
  parameter int TIME_W   = 32,
  parameter int AVG_LOG2 = 3,
  parameter int TOL      = 16,
  parameter int TIMEOUT  = 1024
) (
  input logic          clock,
  input logic          reset,
  pri_analyzer_if.slave bus
);

  localparam int WIN   = 1 << AVG_LOG2;
  localparam int SUM_W = TIME_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FIRST  = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Truncating divide by the window length: the top TIME_W bits of the sum.
  function automatic logic [TIME_W-1:0] win_avg(input logic [SUM_W-1:0] s);
    return s[AVG_LOG2 +: TIME_W];
  endfunction

  logic [1:0]        state_q, state_d;
  logic [TIME_W-1:0] pc_prev_q, pc_prev_d;
  logic [TIME_W-1:0] toa_prev_q, toa_prev_d;
  logic [TIME_W-1:0] pri_q, pri_d;
  logic [TIME_W-1:0] avg_q, avg_d;
  logic [TIME_W-1:0] min_q, min_d;
  logic [TIME_W-1:0] max_q, max_d;
  logic [TIME_W-1:0] win_min_q, win_min_d;
  logic [TIME_W-1:0] win_max_q, win_max_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              pri_valid_q, pri_valid_d;
  logic              stable_q, stable_d;
  logic              window_done_q, window_done_d;
  logic [15:0]       resync_q, resync_d;

  logic              evt;
  logic              in_seq;
  logic [TIME_W-1:0] interval;
  logic [SUM_W-1:0]  sum_next;
  logic [CNT_W-1:0]  cnt_next;
  logic [TIME_W-1:0] min_next;
  logic [TIME_W-1:0] max_next;
  logic              win_full;

  assign evt      = bus.enable && (bus.PC != pc_prev_q);
  assign in_seq   = (bus.PC - pc_prev_q) == TIME_W'(1);
  assign interval = bus.TOA - toa_prev_q;  // modulo 2^TIME_W, wrap-safe

  // An empty window (cnt == 0) seeds sum/min/max from the current interval.
  assign sum_next = ((cnt_q == '0) ? '0 : sum_q) + SUM_W'(interval);
  assign cnt_next = cnt_q + CNT_W'(1);
  assign min_next = ((cnt_q == '0) || (interval < win_min_q)) ? interval : win_min_q;
  assign max_next = ((cnt_q == '0) || (interval > win_max_q)) ? interval : win_max_q;
  assign win_full = (cnt_next == CNT_W'(WIN));

  always_comb begin
    state_d       = state_q;
    pc_prev_d     = pc_prev_q;
    toa_prev_d    = toa_prev_q;
    pri_d         = pri_q;
    avg_d         = avg_q;
    min_d         = min_q;
    max_d         = max_q;
    win_min_d     = win_min_q;
    win_max_d     = win_max_q;
    sum_d         = sum_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    pri_valid_d   = pri_valid_q;
    stable_d      = stable_q;
    window_done_d = 1'b0;
    resync_d      = resync_q;

    if (bus.enable) begin
      pc_prev_d = bus.PC;
      if (evt) begin
        tmo_d      = '0;
        toa_prev_d = bus.TOA;
        if (state_q == S_IDLE) begin
          state_d = S_FIRST;
          sum_d   = '0;
          cnt_d   = '0;
        end else if (!in_seq) begin
          // Missed or repeated pulses: restart from this TOA, keep published stats.
          resync_d = sat_inc16(resync_q);
          state_d  = S_FIRST;
          sum_d    = '0;
          cnt_d    = '0;
        end else begin
          pri_d     = interval;
          win_min_d = min_next;
          win_max_d = max_next;
          if (win_full) begin
            avg_d         = win_avg(sum_next);
            min_d         = min_next;
            max_d         = max_next;
            stable_d      = (max_next - min_next) <= TIME_W'(TOL);
            pri_valid_d   = 1'b1;
            window_done_d = 1'b1;
            sum_d         = '0;
            cnt_d         = '0;
            state_d       = S_LOCKED;
          end else begin
            sum_d = sum_next;
            cnt_d = cnt_next;
            if (state_q == S_FIRST) state_d = S_ACCUM;
          end
        end
      end else if (state_q != S_IDLE) begin
        // Lost the pulse train: drop lock but keep the last measured values.
        if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          pri_valid_d = 1'b0;
          stable_d    = 1'b0;
          sum_d       = '0;
          cnt_d       = '0;
          tmo_d       = '0;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_prev_q     <= '0;
      toa_prev_q    <= '0;
      pri_q         <= '0;
      avg_q         <= '0;
      min_q         <= '0;
      max_q         <= '0;
      win_min_q     <= '0;
      win_max_q     <= '0;
      sum_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      pri_valid_q   <= 1'b0;
      stable_q      <= 1'b0;
      window_done_q <= 1'b0;
      resync_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_prev_q     <= pc_prev_d;
      toa_prev_q    <= toa_prev_d;
      pri_q         <= pri_d;
      avg_q         <= avg_d;
      min_q         <= min_d;
      max_q         <= max_d;
      win_min_q     <= win_min_d;
      win_max_q     <= win_max_d;
      sum_q         <= sum_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      pri_valid_q   <= pri_valid_d;
      stable_q      <= stable_d;
      window_done_q <= window_done_d;
      resync_q      <= resync_d;
    end
  end

  assign bus.PRI         = pri_q;
  assign bus.PRI_AVG     = avg_q;
  assign bus.PRI_MIN     = min_q;
  assign bus.PRI_MAX     = max_q;
  assign bus.pri_valid   = pri_valid_q;
  assign bus.stable      = stable_q;
  assign bus.window_done = window_done_q;
  assign bus.resync_cnt  = resync_q;

endmodule

// File: tb/tb_pri_analyzer.sv
// Directed bench for pri_analyzer: a table of pulses with hand-computed
// statistics, then enable-freeze, timeout and mid-window reset sequences.
module tb_pri_analyzer;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  pri_analyzer_if #(.TIME_W(32)) bus ();

  pri_analyzer #(
    .TIME_W(32), .AVG_LOG2(3), .TOL(16), .TIMEOUT(1024)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] toa;
    logic [31:0] pri;
    logic        done;
    logic        valid;
    logic [31:0] avg;
    logic [31:0] mn;
    logic [31:0] mx;
    logic        st;
    logic [15:0] rs;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [31:0] pc, toa, pri, input logic done, valid,
                              input logic [31:0] avg, mn, mx, input logic st,
                              input logic [15:0] rs);
    vec_t v;
    v.pc = pc; v.toa = toa; v.pri = pri; v.done = done; v.valid = valid;
    v.avg = avg; v.mn = mn; v.mx = mx; v.st = st; v.rs = rs;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive a new PC/TOA at a falling edge; return after the sampling rising edge.
  task automatic drive_pulse(input logic [31:0] pc, input logic [31:0] toa);
    bus.PC  = pc;
    bus.TOA = toa;
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".PRI"},         bus.PRI, 0);
    check({tag, ".PRI_AVG"},     bus.PRI_AVG, 0);
    check({tag, ".PRI_MIN"},     bus.PRI_MIN, 0);
    check({tag, ".PRI_MAX"},     bus.PRI_MAX, 0);
    check({tag, ".pri_valid"},   bus.pri_valid, 0);
    check({tag, ".stable"},      bus.stable, 0);
    check({tag, ".window_done"}, bus.window_done, 0);
    check({tag, ".resync_cnt"},  bus.resync_cnt, 0);
  endtask

  initial begin
    // Periodic window: 8 intervals of 100.
    vt.push_back(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 2; k <= 8; k++)
      vt.push_back(mk(k, 10 + 100 * (k - 1), 100, 0, 0, 0, 0, 0, 0, 0));
    vt.push_back(mk(9, 810, 100, 1, 1, 100, 100, 100, 1, 0));
    // Jittered window: 100,100,100,100,130,100,100,100 -> 830>>3 = 103.
    vt.push_back(mk(10,  910, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(11, 1010, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(12, 1110, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(13, 1210, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(14, 1340, 130, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(15, 1440, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(16, 1540, 100, 0, 1, 100, 100, 100, 1, 0));
    vt.push_back(mk(17, 1640, 100, 1, 1, 103, 100, 130, 0, 0));
    // Partial window, then PC skips 21: resync to a TOA just below the wrap point.
    vt.push_back(mk(18, 1740, 100, 0, 1, 103, 100, 130, 0, 0));
    vt.push_back(mk(19, 1840, 100, 0, 1, 103, 100, 130, 0, 0));
    vt.push_back(mk(20, 1940, 100, 0, 1, 103, 100, 130, 0, 0));
    vt.push_back(mk(22, 32'hFFFF_FFF0, 100, 0, 1, 103, 100, 130, 0, 1));
    // TOA wraps: 0x50 - 0xFFFFFFF0 = 0x60, then a clean window of 96s.
    vt.push_back(mk(23, 32'h50, 32'h60, 0, 1, 103, 100, 130, 0, 1));
    for (int k = 24; k <= 29; k++)
      vt.push_back(mk(k, 80 + 96 * (k - 23), 96, 0, 1, 103, 100, 130, 0, 1));
    vt.push_back(mk(30, 752, 96, 1, 1, 96, 96, 96, 1, 1));

    reset      = 1'b1;
    bus.enable = 1'b1;
    bus.PC     = '0;
    bus.TOA    = '0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    foreach (vt[i]) begin
      drive_pulse(vt[i].pc, vt[i].toa);
      check($sformatf("v%0d.PRI", i),         bus.PRI, vt[i].pri);
      check($sformatf("v%0d.window_done", i), bus.window_done, vt[i].done);
      check($sformatf("v%0d.pri_valid", i),   bus.pri_valid, vt[i].valid);
      check($sformatf("v%0d.PRI_AVG", i),     bus.PRI_AVG, vt[i].avg);
      check($sformatf("v%0d.PRI_MIN", i),     bus.PRI_MIN, vt[i].mn);
      check($sformatf("v%0d.PRI_MAX", i),     bus.PRI_MAX, vt[i].mx);
      check($sformatf("v%0d.stable", i),      bus.stable, vt[i].st);
      check($sformatf("v%0d.resync_cnt", i),  bus.resync_cnt, vt[i].rs);
      @(negedge clock);
      check($sformatf("v%0d.done_gap", i),    bus.window_done, 0);
    end

    // enable low for 5000 cycles with PC wiggling: nothing may change, no timeout.
    bus.enable = 1'b0;
    repeat (100) @(negedge clock);
    bus.PC = 31; bus.TOA = 9999;
    repeat (100) @(negedge clock);
    check("freeze.PRI", bus.PRI, 96);
    check("freeze.resync_cnt", bus.resync_cnt, 1);
    bus.PC = 30; bus.TOA = 752;
    repeat (4800) @(negedge clock);
    check("freeze.pri_valid", bus.pri_valid, 1);
    check("freeze.stable", bus.stable, 1);
    bus.enable = 1'b1;

    // Event landing exactly on the expiry cycle keeps lock.
    drive_pulse(31, 848);
    check("tmo.pulse31.PRI", bus.PRI, 96);
    repeat (1023) @(negedge clock);
    check("tmo.pre_coincide.valid", bus.pri_valid, 1);
    drive_pulse(32, 1000);
    check("tmo.coincide.valid", bus.pri_valid, 1);
    check("tmo.coincide.PRI", bus.PRI, 152);
    repeat (1023) @(negedge clock);
    check("tmo.1023.valid", bus.pri_valid, 1);
    @(negedge clock);
    check("tmo.1024.valid", bus.pri_valid, 0);
    check("tmo.1024.stable", bus.stable, 0);
    check("tmo.1024.PRI_AVG", bus.PRI_AVG, 96);
    check("tmo.1024.PRI", bus.PRI, 152);

    // From IDLE: first pulse only re-arms; then 5 intervals of 100 and a reset.
    drive_pulse(33, 5000);
    check("rearm.PRI", bus.PRI, 152);
    check("rearm.resync_cnt", bus.resync_cnt, 1);
    for (int k = 34; k <= 38; k++) drive_pulse(k, 5000 + 100 * (k - 33));
    check("mid.PRI", bus.PRI, 100);
    check("mid.window_done", bus.window_done, 0);
    reset  = 1'b1;
    bus.PC = 0; bus.TOA = 0;
    @(negedge clock);
    check_all_zero("midreset");
    reset = 1'b0;
    @(negedge clock);
    drive_pulse(1, 7000);
    check("post.first.PRI", bus.PRI, 0);
    check("post.first.valid", bus.pri_valid, 0);
    drive_pulse(2, 7077);
    check("post.second.PRI", bus.PRI, 77);
    check("post.second.resync", bus.resync_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
